// File: rtl/fir_decim_fifo.sv
// Boxcar decimator for the FIR output stream. It averages DECIM samples with rounding
// and queues the results in a show-ahead FIFO that has a sticky overflow flag.
module fir_decim_fifo #(
   parameter int DATA_W = 16,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int SH    = $clog2(DECIM);
   localparam int ACC_W = DATA_W + SH;
   localparam int PH_W  = (SH > 0) ? SH : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam logic [PH_W-1:0]         PH_LAST   = PH_W'(DECIM - 1);
   localparam logic signed [ACC_W-1:0] RND       = ACC_W'(DECIM / 2);
   localparam logic [LW-1:0]           LVL_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0]           LVL_ONE   = LW'(1);
   localparam logic [LW-1:0]           LVL_ZERO  = LW'(0);

   logic signed [ACC_W-1:0] r_acc;
   logic [PH_W-1:0]         r_phase;
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [LW-1:0]           r_level;
   logic                    r_ovf;
   logic                    r_out_valid;
   logic [DATA_W-1:0]       r_out_data;
   logic [DATA_W-1:0]       r_mem [DEPTH];

   logic signed [ACC_W-1:0] w_in_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_rnd;
   logic [DATA_W-1:0]       w_result;
   logic                    w_unused;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_wr;
   logic [AW-1:0]           w_rd_next;
   logic [LW-1:0]           w_level_next;
   logic [DATA_W-1:0]       w_head_next;

   // The full group sum plus half an LSB cannot leave ACC_W bits, so no guard bit is needed.
   assign w_in_ext  = ACC_W'($signed(in_data));
   assign w_sum     = r_acc + w_in_ext;
   assign w_rnd     = w_sum + RND;
   assign w_result  = w_rnd[ACC_W-1:SH];
   assign w_unused  = ^w_rnd;

   assign w_push    = in_valid && (r_phase == PH_LAST);
   assign w_pop     = r_out_valid && out_ready;
   assign w_full    = (r_level == LVL_FULL);
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_rd_next = r_rd_ptr + AW'(w_pop);

   always_comb begin
      w_level_next = r_level;
      w_head_next  = r_out_data;
      if (w_wr && !w_pop) begin
         w_level_next = r_level + LVL_ONE;
      end else if (!w_wr && w_pop) begin
         w_level_next = r_level - LVL_ONE;
      end else begin
         w_level_next = r_level;
      end
      // The new head is the fresh result when no older entry survives this edge.
      if (w_level_next == LVL_ZERO) begin
         w_head_next = r_out_data;
      end else if ((r_level == LVL_ZERO) || ((r_level == LVL_ONE) && w_pop)) begin
         w_head_next = w_result;
      end else begin
         w_head_next = r_mem[w_rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && !flush) begin
         r_mem[r_wr_ptr] <= w_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_phase     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         r_acc       <= '0;
         r_phase     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (in_valid) begin
            if (w_push) begin
               r_acc   <= '0;
               r_phase <= '0;
            end else begin
               r_acc   <= w_sum;
               r_phase <= r_phase + PH_W'(1);
            end
         end
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end
         r_rd_ptr    <= w_rd_next;
         r_level     <= w_level_next;
         r_out_valid <= (w_level_next != LVL_ZERO);
         r_out_data  <= w_head_next;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign level     = r_level;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Self-checking bench for fir_decim_fifo (DECIM=4, DEPTH=8). A negedge monitor models the
// averaging and FIFO behaviour with a scoreboard queue. Scenario tasks check the plan's fixed points.
module tb_fir_decim_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  level;
   logic        overflow;

   int total = 0;
   int bad   = 0;
   logic [15:0] q[$];

   logic [15:0] vin  [0:11] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE,
                                16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
   logic [15:0] vexp [0:2]  = '{16'h0003, 16'hFFFF, 16'h5FFF};

   always #5 clk = ~clk;

   fir_decim_fifo #(.DATA_W(16), .DECIM(4), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .overflow(overflow)
   );

   // Reference model: sums groups of 4, rounds half up, and tracks FIFO contents and the overflow flag.
   task automatic monitor();
      int m_acc = 0;
      int m_ph  = 0;
      bit m_ovf = 1'b0;
      int s;
      int r;
      bit pop;
      bit room;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            total++;
            if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || out_data !== 16'h0000) begin
               bad++;
               $display("FAIL reset_outputs: got v=%b lvl=%0d ovf=%b d=%h want 0 0 0 0000",
                        out_valid, level, overflow, out_data);
            end
            q.delete();
            m_acc = 0; m_ph = 0; m_ovf = 1'b0;
         end else begin
            total++;
            if (level !== 4'(q.size())) begin
               bad++;
               $display("FAIL level: got %0d want %0d at %0t", level, q.size(), $time);
            end
            total++;
            if (out_valid !== (q.size() != 0)) begin
               bad++;
               $display("FAIL out_valid: got %b want %b at %0t", out_valid, (q.size() != 0), $time);
            end
            total++;
            if (overflow !== m_ovf) begin
               bad++;
               $display("FAIL overflow: got %b want %b at %0t", overflow, m_ovf, $time);
            end
            if (q.size() != 0) begin
               total++;
               if (out_data !== q[0]) begin
                  bad++;
                  $display("FAIL out_data: got %h want %h at %0t", out_data, q[0], $time);
               end
            end
            if (flush) begin
               q.delete();
               m_acc = 0; m_ph = 0; m_ovf = 1'b0;
            end else begin
               pop  = (q.size() != 0) && out_ready;
               room = (q.size() < 8) || pop;
               if (pop) e = q.pop_front();
               if (in_valid) begin
                  s = m_acc + int'($signed(in_data));
                  if (m_ph == 3) begin
                     r = (s + 2) >>> 2;
                     e = r[15:0];
                     if (room) q.push_back(e);
                     else m_ovf = 1'b1;
                     m_acc = 0; m_ph = 0;
                  end else begin
                     m_acc = s; m_ph++;
                  end
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (out_valid && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (out_valid !== 1'b0 || level !== 4'd0) begin
         bad++;
         $display("FAIL drain: got v=%b lvl=%0d after %0d cycles want 0 0", out_valid, level, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = 16'h1234;
         tick();
         total++;
         if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL hold_reset: got v=%b lvl=%0d ovf=%b d=%h want 0 0 0 0000",
                     out_valid, level, overflow, out_data);
         end
      end
      rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0001);
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
         bad++;
         $display("FAIL first_group: got v=%b d=%h want 1 0001", out_valid, out_data);
      end
      tick();
   endtask

   task automatic test_square();
      logic [15:0] d;
      for (int g = 0; g < 2; g++) begin
         d = (g == 0) ? 16'h7FFF : 16'h8000;
         for (int k = 0; k < 4; k++) begin
            send(d);
            if (k == 3) begin
               total++;
               if (out_valid !== 1'b1 || out_data !== d) begin
                  bad++;
                  $display("FAIL square_out: got v=%b d=%h want 1 %h", out_valid, out_data, d);
               end
            end
            tick();
         end
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL square_one_cycle: got v=%b want 0", out_valid);
         end
      end
   endtask

   task automatic test_rounding();
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 4; k++) send(vin[g*4 + k]);
         total++;
         if (out_valid !== 1'b1 || out_data !== vexp[g]) begin
            bad++;
            $display("FAIL rounding_%0d: got v=%b d=%h want 1 %h", g, out_valid, out_data, vexp[g]);
         end
         tick();
      end
   endtask

   task automatic test_overflow();
      int cnt = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 36; i++) send(16'(i * 37 + 5));
      total++;
      if (level !== 4'd8 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL fill_overflow: got lvl=%0d ovf=%b want 8 1", level, overflow);
      end
      out_ready = 1'b1;
      while (out_valid && cnt < 20) begin
         cnt++;
         tick();
      end
      total++;
      if (cnt !== 8 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_count: got %0d pops v=%b want 8 0", cnt, out_valid);
      end
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL overflow_sticky: got %b want 1", overflow);
      end
      do_flush();
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL overflow_flush: got %b want 0", overflow);
      end
   endtask

   task automatic test_full_pushpop();
      out_ready = 1'b0;
      for (int i = 0; i < 32; i++) send(16'(i * 101 - 900));
      total++;
      if (level !== 4'd8) begin
         bad++;
         $display("FAIL full_level: got %0d want 8", level);
      end
      for (int i = 0; i < 3; i++) send(16'h0555);
      out_ready = 1'b1;
      send(16'h0555);
      total++;
      if (level !== 4'd8 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL full_pushpop: got lvl=%0d ovf=%b want 8 0", level, overflow);
      end
      drain();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) send(16'(i * 3));
      total++;
      if (level !== 4'd3) begin
         bad++;
         $display("FAIL pre_flush_level: got %0d want 3", level);
      end
      send(16'h0100);
      send(16'h0200);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h7000;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      total++;
      if (level !== 4'd0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_clear: got lvl=%0d v=%b want 0 0", level, out_valid);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(16'h0004);
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0004) begin
         bad++;
         $display("FAIL post_flush: got v=%b d=%h want 1 0004", out_valid, out_data);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_flush_single: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_rst_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(16'h0040);
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || level !== 4'd0 || out_data !== 16'h0000) begin
         bad++;
         $display("FAIL async_reset: got v=%b lvl=%0d d=%h want 0 0 0000", out_valid, level, out_data);
      end
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(16'h0008);
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0008) begin
         bad++;
         $display("FAIL rst_fresh_group: got v=%b d=%h want 1 0008", out_valid, out_data);
      end
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_square();
      test_rounding();
      test_overflow();
      test_full_pushpop();
      test_flush();
      test_rst_mid();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
